// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: ROM read bus plus instruction handshake between the fetch
// sequencer and its neighbours.
//   rom_addr / rom_read_en      fetch -> ROM   byte address and read enable
//   rom_instruction             ROM -> fetch   big-endian word at rom_addr
//   instr / instr_pc            fetch -> CU    captured word and its address
//   instr_valid / instr_ready   valid/ready handshake toward the control unit
// master = fetch sequencer side, slave = ROM/control-unit side.
interface ifetch_ctrl_if;
  logic [31:0] rom_addr;
  logic        rom_read_en;
  logic [31:0] rom_instruction;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output rom_addr, rom_read_en, instr, instr_pc, instr_valid,
    input  rom_instruction, instr_ready
  );

  modport slave (
    input  rom_addr, rom_read_en, instr, instr_pc, instr_valid,
    output rom_instruction, instr_ready
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer for the multicycle CPU.
// Owns the PC, reads the ROM with a fixed ROM_LAT-cycle read, offers each
// fetched word on a valid/ready handshake and accepts branch/jump redirects.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             leave IDLE and fetch at the current PC
//   halt_req          return to IDLE after the current handshake
//   redirect          load redirect_pc as the next fetch address
//   redirect_pc       redirect target
//   fault             illegal fetch address (misaligned or outside the ROM)
//   busy              sequencer not idle
//   bus               ROM bus + instruction handshake (master side)
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned ROM_BYTES = 128,
  parameter int unsigned ROM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic        busy,
  ifetch_ctrl_if.master bus
);

  localparam int unsigned   CW       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROM_LAT - 1);
  localparam logic [31:0]   PC_MAX   = 32'(ROM_BYTES - 4);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic          xfer;

  // Unsigned compare: addresses that wrapped past 2^32 land high and fail.
  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= PC_MAX);
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    xfer       = (state_q == S_HOLD) && bus.instr_ready;

    case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redirect_pc;
        // pc_d already holds the redirect target when both arrive together.
        if (start) begin
          cnt_d   = '0;
          state_d = legal(pc_d) ? S_FETCH : S_FAULT;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          cnt_d   = '0;
          state_d = legal(redirect_pc) ? S_FETCH : S_FAULT;
        end else if (cnt_q == CNT_LAST) begin
          instr_d    = bus.rom_instruction;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          cnt_d      = '0;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        // A redirect without a transfer drops the held word; halt only
        // takes effect together with a transfer.
        if (redirect || xfer) begin
          if (redirect) pc_d = redirect_pc;
          cnt_d = '0;
          if (xfer && halt_req) state_d = S_IDLE;
          else                  state_d = legal(pc_d) ? S_FETCH : S_FAULT;
        end
      end
      S_FAULT: begin
        if (redirect) begin
          pc_d  = redirect_pc;
          cnt_d = '0;
          if (legal(redirect_pc)) state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // All outputs come straight from flops so reset reaches them immediately.
  assign bus.rom_addr    = pc_q;
  assign bus.rom_read_en = (state_q == S_FETCH);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign fault           = (state_q == S_FAULT);
  assign busy            = (state_q != S_IDLE);

endmodule
